fxp_accum: RTL and testbench
============================

FXP_ACCUM -- requirements
Module: fxp_accum

Interface
REQ-001 Parameter IN_WI, default 8: integer bits of the signed input word, sign bit included.
REQ-002 Parameter IN_WF, default 9: fractional bits of the input word.
REQ-003 Parameter GUARD, default 4: extra integer guard bits in the internal accumulator.
REQ-004 Parameter OUT_WI, default 8: integer bits of the signed output word.
REQ-005 Parameter OUT_WF, default 8: fractional bits of the output word; OUT_WF <= IN_WF is required.
REQ-006 Parameter ROUND, default 1: 1 = round half toward +inf when fractional bits are dropped; 0 = truncate (floor).
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rstn  input  1  reset, synchronous, active-low.
REQ-009 in  input  IN_WI+IN_WF  signed two's-complement sample, typically one fxp_mul product.
REQ-010 in_valid  input  1  in and in_last are valid this cycle.
REQ-011 in_last  input  1  marks the final sample of the current sum.
REQ-012 in_ready  output  1  block accepts a sample this cycle.
REQ-013 out  output  OUT_WI+OUT_WF  signed, rounded and saturated sum.
REQ-014 out_valid  output  1  out and overflow hold a result.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 overflow  output  1  the result was saturated or the accumulator wrapped during the sum.

Function
REQ-017 The block SHALL have two states:
- ACC: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-018 The accumulator SHALL be signed, with width IN_WI+GUARD+IN_WF, and SHALL share the input's binary point.
REQ-019 Input acceptance: an input is accepted when in_valid=1 and in_ready=1. On acceptance, acc <= acc + sign_extend(in).
REQ-020 Wrap detection: if that add overflows the accumulator width, a sticky wrap flag SHALL set and stay set until the result is drained.
REQ-021 Accepting a sample with in_last=1 SHALL:
- move the block ACC->HOLD;
- register out and overflow, computed from the final sum including that sample.
REQ-022 Output conversion: when ROUND=1 and IN_WF>OUT_WF, add 1 at bit IN_WF-OUT_WF-1; then shift arithmetically right by IN_WF-OUT_WF.
REQ-023 Saturation: the converted value SHALL saturate to the range [-2^(OUT_WI+OUT_WF-1), 2^(OUT_WI+OUT_WF-1)-1].
REQ-024 overflow SHALL be 1 when saturation occurred or the wrap flag was set. When the wrap flag is set, out SHALL saturate toward the sign of the last valid sum.
REQ-025 Latency: out_valid SHALL assert on the cycle after the in_last handshake.
REQ-026 Hold behaviour: in HOLD, out and overflow SHALL stay stable until out_ready=1.
REQ-027 Drain: the output handshake SHALL clear acc and the wrap flag and return the block to ACC. in_ready SHALL reassert on the next cycle, giving one bubble cycle.
REQ-028 Inputs in HOLD: in_valid SHALL be ignored in HOLD, with no state change.
REQ-029 A single in_last sample with no prior samples SHALL produce that sample, converted.
REQ-030 in_valid=0 in ACC SHALL leave acc unchanged.

Reset
REQ-031 rstn=0 at a clock edge SHALL set:
- state=ACC;
- acc=0 and wrap flag=0;
- out=0, out_valid=0, overflow=0.
REQ-032 Reset asserted mid-sum or in HOLD SHALL discard all partial or pending results. in_ready SHALL read 1 on the first cycle after rstn returns high.

Verification (defaults: input 8.9 format, 1.0=0x00200; output 8.8 format, 1.0=0x0100)
REQ-033 Sum: inputs 0x00400 (2.0), 0x00200 (1.0), 0x1FF00 (-0.5, last) -> one cycle later out=0x0280, overflow=0, out_valid=1.
REQ-034 Rounding: single sample 0x00001 (2^-9, last):
- ROUND=1 -> out=0x0001;
- ROUND=0 -> out=0x0000;
- input 0x1FFFF with ROUND=1 -> out=0x0000.
REQ-035 Saturation:
- 0x0FE00 (127.0) + 0x0FE00 (last) -> out=0x7FFF, overflow=1;
- 0x10000 (-128.0) + 0x1FE00 (-1.0, last) -> out=0x8000, overflow=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 with changing data -> out stable, in_ready=0, acc unaffected. On out_ready=1, the next sum starts from 0.
REQ-037 Reset: rstn=0 after two accepted samples -> all outputs 0. A following single sample 0x00200 (last) -> out=0x0100.
REQ-038 Wrap: GUARD=0, five samples of 0x0FE00 -> overflow=1, out=0x7FFF.

Source files
------------

// File: rtl/fxp_accum_if.sv
// fxp_accum_if: sample-in / result-out handshake bundle for the fixed-point accumulator
interface fxp_accum_if #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    modport master (output in, in_valid, in_last, out_ready, input in_ready, out, out_valid, overflow);
    modport slave  (input in, in_valid, in_last, out_ready, output in_ready, out, out_valid, overflow);
endinterface

// File: rtl/fxp_accum.sv
// fxp_accum: signed fixed-point accumulator with rounding, saturation and sticky wrap detection
module fxp_accum #(
    parameter int IN_WI  = 8,
    parameter int IN_WF  = 9,
    parameter int GUARD  = 4,
    parameter int OUT_WI = 8,
    parameter int OUT_WF = 8,
    parameter int ROUND  = 1
) (
    input logic        clk,
    input logic        rstn,
    fxp_accum_if.slave bus
);
    localparam int AW = IN_WI + GUARD + IN_WF;
    localparam int OW = OUT_WI + OUT_WF;
    localparam int SH = IN_WF - OUT_WF;
    localparam int RB = (ROUND != 0 && SH > 0) ? (1 << (SH - 1)) : 0;
    localparam logic signed [AW:0] RBV  = (AW + 1)'(RB);
    localparam logic signed [AW:0] MAXV = (AW + 1)'((1 << (OW - 1)) - 1);
    localparam logic signed [AW:0] MINV = -MAXV - 1;

    typedef enum logic {ACC, HOLD} state_t;
    state_t state, state_nxt;

    logic signed [AW-1:0] acc, ext, sum;
    logic signed [AW:0]   rnd, shifted;
    logic                 wrap, wrap_neg, add_wrap, wrap_any, neg_dir, sat_hi, sat_lo;
    logic                 accept, drain;
    logic [OW-1:0]        res;

    // datapath: next sum, wrap direction, rounding and saturation of the final value
    always_comb begin
        ext      = AW'(signed'(bus.in));
        sum      = acc + ext;
        add_wrap = (acc[AW-1] == ext[AW-1]) && (sum[AW-1] != acc[AW-1]);
        wrap_any = wrap | add_wrap;
        neg_dir  = add_wrap ? acc[AW-1] : wrap_neg;
        rnd      = (AW + 1)'(sum) + RBV;
        shifted  = rnd >>> SH;
        sat_hi   = wrap_any ? !neg_dir : (shifted > MAXV);
        sat_lo   = wrap_any ? neg_dir  : (shifted < MINV);
        res      = sat_hi ? MAXV[OW-1:0] : sat_lo ? MINV[OW-1:0] : shifted[OW-1:0];
    end

    // next state and handshake outputs derived from the state
    always_comb begin
        bus.in_ready  = (state == ACC);
        bus.out_valid = (state == HOLD);
        accept        = bus.in_ready && bus.in_valid;
        drain         = bus.out_valid && bus.out_ready;
        state_nxt     = (accept && bus.in_last) ? HOLD : drain ? ACC : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= ACC;
        else       state <= state_nxt;
    end

    // accumulator, sticky wrap flag and registered result
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc          <= '0;
            wrap         <= 1'b0;
            wrap_neg     <= 1'b0;
            bus.out      <= '0;
            bus.overflow <= 1'b0;
        end else if (drain) begin
            acc      <= '0;
            wrap     <= 1'b0;
            wrap_neg <= 1'b0;
        end else if (accept) begin
            acc      <= sum;
            wrap     <= wrap_any;
            wrap_neg <= neg_dir;
            if (bus.in_last) begin
                bus.out      <= res;
                bus.overflow <= wrap_any | sat_hi | sat_lo;
            end
        end
    end
endmodule

// File: tb/tb_fxp_accum.sv
// tb_fxp_accum: directed checks of summing, rounding, saturation, wrap, backpressure and reset
module tb_fxp_accum;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int tests = 0;
    int fails = 0;

    fxp_accum_if #(.IN_W(17), .OUT_W(16)) b0 ();
    fxp_accum_if #(.IN_W(17), .OUT_W(16)) b1 ();
    fxp_accum_if #(.IN_W(17), .OUT_W(16)) b2 ();

    fxp_accum dut0 (.clk(clk), .rstn(rstn), .bus(b0));
    fxp_accum #(.ROUND(0)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
    fxp_accum #(.GUARD(0)) dut2 (.clk(clk), .rstn(rstn), .bus(b2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [16:0] d, input logic v, input logic last);
        b0.in = d; b0.in_valid = v; b0.in_last = last;
        b1.in = d; b1.in_valid = v; b1.in_last = last;
        b2.in = d; b2.in_valid = v; b2.in_last = last;
    endtask

    task automatic send(input logic [16:0] d, input logic last);
        drive(d, 1'b1, last);
        tick();
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        b0.out_ready = 1'b1; b1.out_ready = 1'b1; b2.out_ready = 1'b1;
        tick();
        b0.out_ready = 1'b0; b1.out_ready = 1'b0; b2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tests++;
        if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0", b0.in_ready, b0.out_valid);
        end
        tests++;
        if (b0.out !== 16'h0000 || b0.overflow !== 1'b0) begin
            fails++; $display("FAIL reset_out got out=%h ovf=%b want out=0000 ovf=0", b0.out, b0.overflow);
        end
    endtask

    task automatic test_sum();
        send(17'h00400, 1'b0);
        tests++;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
            fails++; $display("FAIL sum_mid got vld=%b rdy=%b want vld=0 rdy=1", b0.out_valid, b0.in_ready);
        end
        send(17'h00200, 1'b0);
        send(17'h1FF00, 1'b1);
        tests++;
        if (b0.out !== 16'h0280 || b0.overflow !== 1'b0 || b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0) begin
            fails++; $display("FAIL sum_out got out=%h ovf=%b vld=%b rdy=%b want out=0280 ovf=0 vld=1 rdy=0", b0.out, b0.overflow, b0.out_valid, b0.in_ready);
        end
        drain();
        tests++;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
            fails++; $display("FAIL sum_drain got vld=%b rdy=%b want vld=0 rdy=1", b0.out_valid, b0.in_ready);
        end
    endtask

    task automatic test_round();
        send(17'h00001, 1'b1);
        tests++;
        if (b0.out !== 16'h0001) begin
            fails++; $display("FAIL round_up got %h want 0001", b0.out);
        end
        tests++;
        if (b1.out !== 16'h0000) begin
            fails++; $display("FAIL round_trunc got %h want 0000", b1.out);
        end
        drain();
        send(17'h1FFFF, 1'b1);
        tests++;
        if (b0.out !== 16'h0000 || b0.overflow !== 1'b0) begin
            fails++; $display("FAIL round_neg got out=%h ovf=%b want out=0000 ovf=0", b0.out, b0.overflow);
        end
        tests++;
        if (b1.out !== 16'hFFFF) begin
            fails++; $display("FAIL trunc_neg got %h want ffff", b1.out);
        end
        drain();
    endtask

    task automatic test_saturate();
        send(17'h0FE00, 1'b0);
        send(17'h0FE00, 1'b1);
        tests++;
        if (b0.out !== 16'h7FFF || b0.overflow !== 1'b1) begin
            fails++; $display("FAIL sat_pos got out=%h ovf=%b want out=7fff ovf=1", b0.out, b0.overflow);
        end
        drain();
        send(17'h10000, 1'b0);
        send(17'h1FE00, 1'b1);
        tests++;
        if (b0.out !== 16'h8000 || b0.overflow !== 1'b1) begin
            fails++; $display("FAIL sat_neg got out=%h ovf=%b want out=8000 ovf=1", b0.out, b0.overflow);
        end
        drain();
    endtask

    task automatic test_backpressure();
        send(17'h00200, 1'b0);
        send(17'h00200, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(17'h0FE00 + 17'(i), 1'b1, i[0]);
            tick();
            tests++;
            if (b0.out !== 16'h0200 || b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1 || b0.overflow !== 1'b0) begin
                fails++; $display("FAIL hold_%0d got out=%h rdy=%b vld=%b ovf=%b want out=0200 rdy=0 vld=1 ovf=0", i, b0.out, b0.in_ready, b0.out_valid, b0.overflow);
            end
        end
        drive('0, 1'b0, 1'b0);
        drain();
        send(17'h00200, 1'b1);
        tests++;
        if (b0.out !== 16'h0100 || b0.overflow !== 1'b0) begin
            fails++; $display("FAIL bp_restart got out=%h ovf=%b want out=0100 ovf=0", b0.out, b0.overflow);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(17'h0FE00, 1'b0);
        send(17'h0FE00, 1'b0);
        rstn = 1'b0;
        tick();
        tests++;
        if (b0.out !== 16'h0000 || b0.overflow !== 1'b0 || b0.out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid got out=%h ovf=%b vld=%b want 0000/0/0", b0.out, b0.overflow, b0.out_valid);
        end
        rstn = 1'b1;
        tests++;
        if (b0.in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_rdy got %b want 1", b0.in_ready);
        end
        send(17'h00200, 1'b1);
        tests++;
        if (b0.out !== 16'h0100 || b0.overflow !== 1'b0) begin
            fails++; $display("FAIL rst_after got out=%h ovf=%b want out=0100 ovf=0", b0.out, b0.overflow);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tests++;
        if (b0.out !== 16'h0000 || b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_hold got out=%h vld=%b rdy=%b want 0000/0/1", b0.out, b0.out_valid, b0.in_ready);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) send(17'h0FE00, i == 4);
        tests++;
        if (b2.out !== 16'h7FFF || b2.overflow !== 1'b1) begin
            fails++; $display("FAIL wrap got out=%h ovf=%b want out=7fff ovf=1", b2.out, b2.overflow);
        end
        drain();
        send(17'h00200, 1'b1);
        tests++;
        if (b2.out !== 16'h0100 || b2.overflow !== 1'b0) begin
            fails++; $display("FAIL wrap_clear got out=%h ovf=%b want out=0100 ovf=0", b2.out, b2.overflow);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        send(17'h00400, 1'b1);
        drain();
        send(17'h1FC00, 1'b1);
        tests++;
        if (b0.out !== 16'hFE00 || b0.overflow !== 1'b0) begin
            fails++; $display("FAIL b2b got out=%h ovf=%b want out=fe00 ovf=0", b0.out, b0.overflow);
        end
        drain();
    endtask

    initial begin
        drive('0, 1'b0, 1'b0);
        b0.out_ready = 1'b0; b1.out_ready = 1'b0; b2.out_ready = 1'b0;
        test_reset();
        test_sum();
        test_round();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
